// File: rtl/camera_pixel_writer.sv
// Camera capture frame-buffer writer: packs RGB565 byte pairs
// into RGB444 words and writes them in raster order.
module camera_pixel_writer #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              capture_en,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic              cam_pvalid,
  input  logic [7:0]        cam_data,
  output logic [ADDR_W-1:0] wraddr,
  output logic [11:0]       wrdata,
  output logic              wren,
  output logic              frame_done,
  output logic              overflow_err
);

  localparam int COL_W = $clog2(H_RES + 1);
  localparam int ROW_W = $clog2(V_RES + 1);
  localparam logic [COL_W-1:0]  COL_MAX = COL_W'(H_RES);
  localparam logic [ROW_W-1:0]  ROW_MAX = ROW_W'(V_RES);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_RES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SYNC,
    ARMED,
    CAPTURE
  } state_t;

  state_t state_q, state_d;

  logic              vsync_q;
  logic              href_q;
  logic              phase_q;
  logic [7:0]        hi_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [ADDR_W-1:0] line_base_q;

  logic              vs_rise;
  logic              vs_fall;
  logic              hr_rise;
  logic              hr_fall;
  logic              in_cap;
  logic              start;
  logic              ph_eff;
  logic [COL_W-1:0]  col_eff;
  logic              room;
  logic [11:0]       pix;

  always_comb begin
    vs_rise = cam_vsync & ~vsync_q;
    vs_fall = ~cam_vsync & vsync_q;
    hr_rise = cam_href & ~href_q;
    hr_fall = ~cam_href & href_q;
    in_cap  = (state_q == CAPTURE);
    start   = (state_q == ARMED) & vs_fall;
    // A strobe on the href rising cycle is the first byte of a new line.
    ph_eff  = hr_rise ? 1'b0 : phase_q;
    col_eff = hr_rise ? '0 : col_q;
    room    = (col_eff < COL_MAX) && (row_q < ROW_MAX);
    pix     = {hi_q[7:4], hi_q[2:0], cam_data[7], cam_data[4:1]};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (capture_en) state_d = WAIT_SYNC;
      WAIT_SYNC: if (cam_vsync) state_d = ARMED;
      ARMED:     if (vs_fall) state_d = CAPTURE;
      CAPTURE: begin
        if (vs_rise) state_d = capture_en ? ARMED : IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= cam_vsync;
      href_q  <= cam_href;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q      <= 1'b0;
      hi_q         <= '0;
      col_q        <= '0;
      row_q        <= '0;
      line_base_q  <= '0;
      wraddr       <= '0;
      wrdata       <= '0;
      wren         <= 1'b0;
      frame_done   <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      wren       <= 1'b0;
      frame_done <= in_cap & vs_rise;
      if (start) begin
        phase_q     <= 1'b0;
        col_q       <= '0;
        row_q       <= '0;
        line_base_q <= '0;
      end else if (in_cap) begin
        if (hr_fall) begin
          phase_q <= 1'b0;
          if ((col_q != '0) && (row_q < ROW_MAX)) begin
            row_q       <= row_q + 1'b1;
            line_base_q <= line_base_q + LINE_STEP;
          end
        end else if (cam_href && cam_pvalid) begin
          if (!ph_eff) begin
            hi_q    <= cam_data;
            phase_q <= 1'b1;
            col_q   <= col_eff;
          end else begin
            phase_q <= 1'b0;
            if (room) begin
              wren   <= 1'b1;
              wraddr <= line_base_q + ADDR_W'(col_eff);
              wrdata <= pix;
              col_q  <= col_eff + 1'b1;
            end else begin
              overflow_err <= 1'b1;
              col_q        <= col_eff;
            end
          end
        end else if (hr_rise) begin
          phase_q <= 1'b0;
          col_q   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_camera_pixel_writer.sv
// Directed bench for camera_pixel_writer on a reduced
// 20x6 frame so a full frame fits in a short run.
module tb_camera_pixel_writer;

  localparam int H  = 20;
  localparam int V  = 6;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          capture_en;
  logic          cam_vsync;
  logic          cam_href;
  logic          cam_pvalid;
  logic [7:0]    cam_data;
  logic [AW-1:0] wraddr;
  logic [11:0]   wrdata;
  logic          wren;
  logic          frame_done;
  logic          overflow_err;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int fd_cnt = 0;
  logic [AW-1:0] last_addr = '0;
  logic [11:0]   last_data = '0;

  camera_pixel_writer #(
    .H_RES (H),
    .V_RES (V),
    .ADDR_W(AW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .capture_en  (capture_en),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_pvalid  (cam_pvalid),
    .cam_data    (cam_data),
    .wraddr      (wraddr),
    .wrdata      (wrdata),
    .wren        (wren),
    .frame_done  (frame_done),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wren) begin
      wr_cnt    = wr_cnt + 1;
      last_addr = wraddr;
      last_data = wrdata;
    end
    if (frame_done) fd_cnt = fd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    cam_pvalid = 1'b1;
    cam_data   = b;
    tick();
    cam_pvalid = 1'b0;
  endtask

  task automatic send_pix(input logic [7:0] hi, input logic [7:0] lo);
    send_byte(hi);
    send_byte(lo);
  endtask

  task automatic line_start();
    cam_href = 1'b1;
    tick();
  endtask

  task automatic line_end();
    cam_href = 1'b0;
    tick();
    tick();
  endtask

  task automatic frame_start();
    cam_vsync = 1'b1;
    tick();
    tick();
    cam_vsync = 1'b0;
    tick();
  endtask

  task automatic frame_end();
    cam_vsync = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    int s;
    int f;
    reset_n    = 1'b0;
    capture_en = 1'b0;
    cam_vsync  = 1'b0;
    cam_href   = 1'b0;
    cam_pvalid = 1'b0;
    cam_data   = 8'h00;
    tick();
    tick();
    @(negedge clk);
    chk("reset_outs", 32'({wren, frame_done, overflow_err, wraddr, wrdata}), 0);
    reset_n = 1'b1;
    tick();

    // single pixel, latency and first address
    capture_en = 1'b1;
    tick();
    frame_start();
    line_start();
    s = wr_cnt;
    send_byte(8'hF8);
    @(negedge clk);
    chk("wren_after_hi", 32'(wren), 0);
    send_byte(8'h00);
    @(negedge clk);
    chk("wren_lat1", 32'(wren), 1);
    chk("first_addr", 32'(wraddr), 0);
    chk("red_pix", 32'(wrdata), 32'h0F00);
    line_end();
    chk("one_write", 32'(wr_cnt - s), 1);

    // colour packing on second line
    line_start();
    send_pix(8'h07, 8'hE0);
    @(negedge clk);
    chk("green_pix", 32'(wrdata), 32'h00F0);
    chk("green_addr", 32'(wraddr), 20);
    send_pix(8'h00, 8'h1F);
    @(negedge clk);
    chk("blue_pix", 32'(wrdata), 32'h000F);
    chk("blue_addr", 32'(wraddr), 21);
    send_pix(8'hFF, 8'hFF);
    @(negedge clk);
    chk("white_pix", 32'(wrdata), 32'h0FFF);
    line_end();
    f = fd_cnt;
    frame_end();
    chk("fd_frame_a", 32'(fd_cnt - f), 1);

    // full frame then one line past the last row
    frame_start();
    s = wr_cnt;
    for (int l = 0; l < V; l++) begin
      line_start();
      for (int p = 0; p < H; p++) begin
        if (l == V - 1 && p == H - 1) send_pix(8'hFF, 8'hFF);
        else send_pix(8'h12, 8'h34);
      end
      line_end();
    end
    chk("full_writes", 32'(wr_cnt - s), H * V);
    chk("full_last_addr", 32'(last_addr), H * V - 1);
    chk("full_last_data", 32'(last_data), 32'h0FFF);
    chk("full_no_ovf", 32'(overflow_err), 0);
    s = wr_cnt;
    line_start();
    send_pix(8'h12, 8'h34);
    send_pix(8'h12, 8'h34);
    line_end();
    chk("row_ovf_writes", 32'(wr_cnt - s), 0);
    chk("row_ovf_flag", 32'(overflow_err), 1);
    f = fd_cnt;
    frame_end();
    chk("fd_frame_b", 32'(fd_cnt - f), 1);

    // reset in the middle of a line
    frame_start();
    line_start();
    send_pix(8'h12, 8'h34);
    send_byte(8'hF8);
    cam_pvalid = 1'b1;
    cam_data   = 8'h00;
    @(posedge clk);
    #1;
    chk("pre_rst_wren", 32'(wren), 1);
    reset_n = 1'b0;
    #1;
    chk("rst_outs", 32'({wren, frame_done, overflow_err, wraddr, wrdata}), 0);
    cam_pvalid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    s = wr_cnt;
    send_pix(8'h12, 8'h34);
    cam_href = 1'b0;
    tick();
    cam_href = 1'b1;
    tick();
    send_pix(8'h12, 8'h34);
    line_end();
    chk("no_sync_writes", 32'(wr_cnt - s), 0);

    // restart, then a five-byte line
    frame_start();
    line_start();
    s = wr_cnt;
    send_byte(8'hF8);
    send_byte(8'h00);
    @(negedge clk);
    chk("restart_addr", 32'(wraddr), 0);
    send_byte(8'h07);
    send_byte(8'hE0);
    send_byte(8'hAA);
    line_end();
    chk("odd_writes", 32'(wr_cnt - s), 2);
    chk("odd_last_addr", 32'(last_addr), 1);
    line_start();
    send_pix(8'h00, 8'h1F);
    @(negedge clk);
    chk("odd_next_addr", 32'(wraddr), 20);
    chk("odd_next_data", 32'(wrdata), 32'h000F);
    line_end();
    s = wr_cnt;
    send_pix(8'h12, 8'h34);
    chk("href_low_writes", 32'(wr_cnt - s), 0);

    // column overflow
    chk("pre_col_ovf", 32'(overflow_err), 0);
    line_start();
    s = wr_cnt;
    for (int p = 0; p < H + 2; p++) send_pix(8'h07, 8'hE0);
    line_end();
    chk("col_ovf_writes", 32'(wr_cnt - s), H);
    chk("col_ovf_last", 32'(last_addr), 59);
    chk("col_ovf_flag", 32'(overflow_err), 1);
    line_start();
    send_pix(8'hFF, 8'hFF);
    @(negedge clk);
    chk("col_ovf_next", 32'(wraddr), 60);
    line_end();

    // vsync rise with a phase-1 byte, capture disabled mid-frame
    capture_en = 1'b0;
    line_start();
    f = fd_cnt;
    send_byte(8'h07);
    cam_pvalid = 1'b1;
    cam_data   = 8'hE0;
    cam_vsync  = 1'b1;
    tick();
    cam_pvalid = 1'b0;
    @(negedge clk);
    chk("edge_wren", 32'(wren), 1);
    chk("edge_fd", 32'(frame_done), 1);
    chk("edge_addr", 32'(wraddr), 80);
    tick();
    cam_href = 1'b0;
    tick();
    tick();
    chk("edge_fd_once", 32'(fd_cnt - f), 1);
    frame_start();
    line_start();
    s = wr_cnt;
    send_pix(8'h12, 8'h34);
    line_end();
    chk("cap_off_writes", 32'(wr_cnt - s), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
